// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, IR, AC and ALU for the 8-bit accumulator CPU; executes control strobes.
// Revision: 1.0
`default_nettype none

module cpu_datapath #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              rd,
  input  logic              wr,
  input  logic              ld_ir,
  input  logic              ld_ac,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              halt,
  input  logic              data_e,
  input  logic              sel,
  output logic [2:0]        opcode,
  output logic              zero,
  output logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] mem_din,
  output logic [DWIDTH-1:0] mem_dout,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              halted,
  output logic [7:0]        icount
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [7:0] ICOUNT_MAX = 8'hFF;

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [DWIDTH-1:0] ac_q, ac_d;
  logic              halted_q, halted_d;
  logic [7:0]        icount_q, icount_d;

  logic [AWIDTH-1:0] operand;
  logic [DWIDTH-1:0] alu_result;

  assign opcode  = ir_q[DWIDTH-1 -: 3];
  assign operand = ir_q[AWIDTH-1:0];

  always_comb begin
    alu_result = ac_q;
    case (opcode)
      OP_ADD:  alu_result = ac_q + mem_din;
      OP_AND:  alu_result = ac_q & mem_din;
      OP_XOR:  alu_result = ac_q ^ mem_din;
      OP_LDA:  alu_result = mem_din;
      OP_HLT, OP_SKZ, OP_STO, OP_JMP: alu_result = ac_q;
      default: alu_result = ac_q;
    endcase
  end

  // Once halted, every architectural load is suppressed; only reset recovers.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    ac_d     = ac_q;
    icount_d = icount_q;
    halted_d = halted_q | halt;
    if (!halted_q) begin
      if (ld_ir) begin
        ir_d = mem_din;
        if (icount_q != ICOUNT_MAX) begin
          icount_d = icount_q + 8'd1;
        end
      end
      if (ld_pc) begin
        pc_d = operand;
      end else if (inc_pc) begin
        pc_d = pc_q + AWIDTH'(1);
      end
      if (ld_ac) begin
        ac_d = alu_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pc_q     <= '0;
      ir_q     <= '0;
      ac_q     <= '0;
      halted_q <= 1'b0;
      icount_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ac_q     <= ac_d;
      halted_q <= halted_d;
      icount_q <= icount_d;
    end
  end

  // zero reflects the AC register so SKZ sees the pre-load value.
  assign zero     = (ac_q == '0);
  assign addr     = sel ? pc_q : operand;
  assign mem_dout = data_e ? ac_q : '0;
  assign mem_rd   = rd;
  assign mem_wr   = wr;
  assign halted   = halted_q;
  assign icount   = icount_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed plus randomized checks of cpu_datapath against an arithmetic reference model.
// Revision: 1.0
`default_nettype none

module tb_cpu_datapath;

  logic       clk;
  logic       rst_;
  logic       rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel;
  logic [7:0] mem_din;
  logic [2:0] opcode;
  logic       zero;
  logic [4:0] addr;
  logic [7:0] mem_dout;
  logic       mem_rd, mem_wr, halted;
  logic [7:0] icount;

  localparam logic [8:0] S_RD   = 9'b1_0000_0000;
  localparam logic [8:0] S_WR   = 9'b0_1000_0000;
  localparam logic [8:0] S_LDIR = 9'b0_0100_0000;
  localparam logic [8:0] S_LDAC = 9'b0_0010_0000;
  localparam logic [8:0] S_LDPC = 9'b0_0001_0000;
  localparam logic [8:0] S_INC  = 9'b0_0000_1000;
  localparam logic [8:0] S_HALT = 9'b0_0000_0100;
  localparam logic [8:0] S_DE   = 9'b0_0000_0010;
  localparam logic [8:0] S_SEL  = 9'b0_0000_0001;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_pc, m_ir, m_ac, m_icount;
  bit m_halted;

  cpu_datapath #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst_(rst_), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .halt(halt), .data_e(data_e), .sel(sel),
    .opcode(opcode), .zero(zero), .addr(addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted),
    .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_ir = 0; m_ac = 0; m_icount = 0; m_halted = 0;
  endfunction

  // One clock cycle with the currently driven inputs; checks combinational outputs, then state.
  task automatic cycle();
    int alu, n_pc, n_ir, n_ac, n_ic;
    bit n_h;
    #1;
    check_val("addr",     32'(addr),     sel ? m_pc : m_ir % 32);
    check_val("opcode",   32'(opcode),   m_ir / 32);
    check_val("zero",     32'(zero),     (m_ac == 0) ? 1 : 0);
    check_val("mem_dout", 32'(mem_dout), data_e ? m_ac : 0);
    check_val("mem_rd",   32'(mem_rd),   32'(rd));
    check_val("mem_wr",   32'(mem_wr),   32'(wr));
    case (m_ir / 32)
      2: alu = (m_ac + int'(mem_din)) % 256;
      3: alu = m_ac & int'(mem_din);
      4: alu = m_ac ^ int'(mem_din);
      5: alu = int'(mem_din);
      default: alu = m_ac;
    endcase
    n_pc = m_pc; n_ir = m_ir; n_ac = m_ac; n_ic = m_icount;
    n_h  = m_halted || halt;
    if (!m_halted) begin
      if (ld_ir) begin
        n_ir = int'(mem_din);
        n_ic = (m_icount < 255) ? m_icount + 1 : 255;
      end
      if (ld_pc)       n_pc = m_ir % 32;
      else if (inc_pc) n_pc = (m_pc + 1) % 32;
      if (ld_ac)       n_ac = alu;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ir = n_ir; m_ac = n_ac; m_icount = n_ic; m_halted = n_h;
    check_val("halted", 32'(halted), 32'(m_halted));
    check_val("icount", 32'(icount), m_icount);
  endtask

  task automatic do_cyc(input logic [8:0] c, input logic [7:0] d);
    {rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel} = c;
    mem_din = d;
    cycle();
  endtask

  // Look at outputs mid-cycle with all strobes idle; no clock edge.
  task automatic look(input logic s, input logic de);
    {rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt} = '0;
    sel = s; data_e = de;
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst_ = 1'b0;
    sel = 1'b1; data_e = 1'b1;
    #1;
    model_reset();
    check_val("rst_addr",   32'(addr),     0);
    check_val("rst_zero",   32'(zero),     1);
    check_val("rst_opcode", 32'(opcode),   0);
    check_val("rst_dout",   32'(mem_dout), 0);
    check_val("rst_halted", 32'(halted),   0);
    check_val("rst_icount", 32'(icount),   0);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  initial begin
    rst_ = 1'b1;
    {rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel} = '0;
    mem_din = 8'h00;
    model_reset();
    @(posedge clk);
    #3;
    async_reset();

    // Fetch and increment
    do_cyc(S_SEL | S_RD | S_LDIR, 8'hA3);
    do_cyc(S_SEL | S_INC, 8'h00);
    look(1'b1, 1'b0);
    check_val("fetch_opcode", 32'(opcode), 5);
    check_val("fetch_pc",     32'(addr),   1);
    check_val("fetch_icount", 32'(icount), 1);
    look(1'b0, 1'b0);
    check_val("fetch_operand", 32'(addr), 32'h03);

    // ALU operations from AC = F0
    do_cyc(S_LDIR, 8'hA0);
    do_cyc(S_LDAC, 8'hF0);
    do_cyc(S_LDIR, 8'h40);
    do_cyc(S_LDAC, 8'h20);
    look(1'b0, 1'b1);
    check_val("add_ac",   32'(mem_dout), 32'h10);
    check_val("add_zero", 32'(zero),     0);
    do_cyc(S_LDIR, 8'h80);
    do_cyc(S_LDAC, 8'h10);
    look(1'b0, 1'b1);
    check_val("xor_ac",   32'(mem_dout), 0);
    check_val("xor_zero", 32'(zero),     1);
    do_cyc(S_LDIR, 8'h60);
    do_cyc(S_LDAC, 8'hFF);
    look(1'b0, 1'b1);
    check_val("and_ac", 32'(mem_dout), 0);

    // PC wrap and ld_pc priority
    do_cyc(S_LDIR, 8'hFF);
    do_cyc(S_LDPC, 8'h00);
    look(1'b1, 1'b0);
    check_val("pc_31", 32'(addr), 31);
    do_cyc(S_INC, 8'h00);
    look(1'b1, 1'b0);
    check_val("pc_wrap", 32'(addr), 0);
    do_cyc(S_LDIR, 8'hE9);
    do_cyc(S_LDPC | S_INC, 8'h00);
    look(1'b1, 1'b0);
    check_val("pc_ldpc_wins", 32'(addr), 9);

    // Store path
    do_cyc(S_LDIR, 8'hA0);
    do_cyc(S_LDAC, 8'h5A);
    do_cyc(S_LDIR, 8'hC7);
    {rd, ld_ir, ld_ac, ld_pc, inc_pc, halt} = '0;
    sel = 1'b0; data_e = 1'b1; wr = 1'b1;
    #1;
    check_val("sto_dout", 32'(mem_dout), 32'h5A);
    check_val("sto_wr",   32'(mem_wr),   1);
    check_val("sto_addr", 32'(addr),     7);
    look(1'b0, 1'b0);
    check_val("sto_dout_off", 32'(mem_dout), 0);

    // Randomized traffic without halt, occasional mid-cycle reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) async_reset();
      do_cyc(9'($urandom) & ~S_HALT, 8'($urandom));
    end

    // Halt with same-cycle AC load, then frozen state under random strobes
    do_cyc(S_LDIR, 8'hA0);
    do_cyc(S_LDAC | S_HALT, 8'h3C);
    look(1'b0, 1'b1);
    check_val("halt_set",  32'(halted),   1);
    check_val("halt_ac",   32'(mem_dout), 32'h3C);
    for (int i = 0; i < 60; i++) begin
      do_cyc(9'($urandom), 8'($urandom));
    end
    check_val("halt_sticky", 32'(halted), 1);
    async_reset();

    // Random traffic with halt permitted
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset();
      do_cyc(($urandom_range(0, 15) == 0) ? 9'($urandom) : (9'($urandom) & ~S_HALT), 8'($urandom));
    end

    // icount saturation
    async_reset();
    for (int i = 0; i < 300; i++) begin
      do_cyc(S_LDIR | S_RD | 9'($urandom & 32'h89), 8'($urandom));
    end
    check_val("icount_sat", 32'(icount), 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_datapath.md
# cpu_datapath

Datapath half of the 8-bit accumulator CPU: holds the program counter, instruction register, and accumulator, plus the ALU. It executes the strobes issued each phase by the `control` sequencer and returns `opcode` and `zero` to it. It sits between `control` and the 32x8 program/data memory, generating the memory address and write data and consuming read data.

## Interface
Parameters:
- `AWIDTH`, 5: address/PC width (memory depth 2^AWIDTH).
- `DWIDTH`, 8: data/accumulator/IR width; opcode is always IR[DWIDTH-1:DWIDTH-3].

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `rd`  in  1  controller memory-read strobe; forwarded to `mem_rd`.
- `wr`  in  1  controller memory-write strobe; forwarded to `mem_wr`.
- `ld_ir`  in  1  load IR from `mem_din`.
- `ld_ac`  in  1  load AC from ALU result.
- `ld_pc`  in  1  load PC from IR operand field.
- `inc_pc`  in  1  increment PC.
- `halt`  in  1  set sticky halted flag.
- `data_e`  in  1  enable AC onto `mem_dout`.
- `sel`  in  1  address select: 1 = PC, 0 = IR operand.
- `opcode`  out  3  IR[7:5] to controller.
- `zero`  out  1  1 when AC == 0.
- `addr`  out  AWIDTH  memory address.
- `mem_din`  in  DWIDTH  memory read data.
- `mem_dout`  out  DWIDTH  memory write data.
- `mem_rd`, `mem_wr`  out  1 each  memory strobes.
- `halted`  out  1  sticky halt status.
- `icount`  out  8  count of instructions fetched, saturating.

## Operation
- Opcode map: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- IR: on `ld_ir`, IR <= `mem_din`. Operand field = IR[AWIDTH-1:0].
- PC: `ld_pc` loads the operand field. Otherwise `inc_pc` increments PC modulo 2^AWIDTH (31 -> 0). If both are asserted, `ld_pc` wins.
- ALU, combinational on current opcode:
  - ADD: AC + `mem_din`, truncated to DWIDTH; carry discarded.
  - AND: AC & `mem_din`.
  - XOR: AC ^ `mem_din`.
  - LDA: `mem_din`.
  - HLT, SKZ, STO, JMP: pass AC unchanged.
- AC: on `ld_ac`, AC <= ALU result.
- `zero` = (AC == 0), combinational from the AC register, never from the ALU output.
- `addr` = `sel` ? PC : operand field, combinational.
- `mem_dout` = `data_e` ? AC : 0.
- `mem_rd` = `rd` and `mem_wr` = `wr`, combinational pass-through. They are not gated by `halted`.
- Halt: `halt` sampled high sets `halted` on the next edge. `halted` clears only on reset. While `halted` = 1, `ld_ir`, `ld_ac`, `ld_pc`, and `inc_pc` are ignored, freezing PC, IR, AC, and `icount`.
- `icount`: increments on each accepted `ld_ir` and saturates at 255.

## Timing
- Reset (`rst_` low, asynchronous): PC = 0, IR = 0, AC = 0, `halted` = 0, `icount` = 0. As a result `opcode` = 0, `zero` = 1, `addr` = 0, `mem_dout` = 0.
- Reset deassertion is not synchronized internally; the bench releases `rst_` on a falling edge of `clk`.
- All register loads take effect at the rising edge on which the strobe is high, so results are visible the following cycle.
- `mem_din` must be stable during the setup window before the rising edge that samples it (`ld_ir` or `ld_ac`).
- Zero latency from IR to `opcode` and from AC to `zero`. The controller's SKZ decision uses AC as it stood before any same-cycle `ld_ac`.
- Reset mid-instruction: every register clears immediately, regardless of which strobes are active.
- `halt` and `ld_ac` in the same cycle: AC loads, and `halted` sets on that same edge.
- Strobes are independent. Any combination is legal; the priorities above resolve conflicts.

## Test plan
- Reset then idle: assert `rst_` = 0 mid-cycle -> PC/AC/IR = 0 and `zero` = 1 immediately, with no clock edge required.
- Fetch/increment: `sel` = 1, `mem_din` = 8'hA3, pulse `ld_ir`, then `inc_pc` -> `opcode` = 5, `addr` shows PC = 1, `icount` = 1. Then with `sel` = 0 -> `addr` = 5'h03.
- ALU ops, with AC preloaded to 8'hF0 via LDA:
  - ADD with `mem_din` = 8'h20 -> AC = 8'h10, `zero` = 0.
  - XOR with 8'h10 -> AC = 0, `zero` = 1.
  - AND with 8'hFF -> AC = 0.
- PC boundaries:
  - PC = 31 with `inc_pc` -> PC = 0.
  - IR = 8'hE9 with `ld_pc` and `inc_pc` both high -> PC = 9.
- Store path: AC = 8'h5A, opcode STO, `sel` = 0, `data_e` = 1, `wr` = 1 -> `mem_dout` = 8'h5A, `mem_wr` = 1, `addr` = IR[4:0]. With `data_e` = 0 -> `mem_dout` = 0.
- Halt/saturation:
  - `halt` pulse -> `halted` = 1; subsequent `ld_ir`/`inc_pc`/`ld_ac` leave all state unchanged; only reset clears it.
  - 300 accepted `ld_ir` pulses -> `icount` = 255.
